// File: rtl/gf2_div_pkg.sv
// Shared types and helpers for the GF(2) polynomial divider.
// Provides the FSM state enum, default widths and the divisor degree encoder.
package gf2_div_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Degree of a polynomial: index of its highest set coefficient.
    // Returns 0 for the zero polynomial; callers flag that case separately.
    function automatic int msb_index(input logic [31:0] v);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) m = i;
        end
        return m;
    endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step over GF(2): shift in a dividend bit, subtract (XOR).
// Ports: r_i working remainder, d_i dividend bit, divisor_i, n_i divisor degree,
//        r_next_o next remainder, q_bit_o quotient bit for this position.
module gf2_div_step #(
    parameter int VW = 8,
    parameter int NW = 3
) (
    input  logic [VW-1:0] r_i,
    input  logic          d_i,
    input  logic [VW-1:0] divisor_i,
    input  logic [NW-1:0] n_i,
    output logic [VW-1:0] r_next_o,
    output logic          q_bit_o
);

    logic [VW:0] r_sh;

    // r_i never holds a coefficient at or above x^n, so the bit shifted
    // out of the top is always zero and VW bits are enough.
    assign r_sh     = {r_i, d_i};
    assign q_bit_o  = r_sh[n_i];
    assign r_next_o = q_bit_o ? VW'(r_sh ^ {1'b0, divisor_i})
                              : VW'(r_sh);

endmodule

// File: rtl/gf2_poly_div.sv
// Sequential carry-less polynomial divider, one dividend bit per clock.
// Ports: clk, rst_n (async low); in_valid/in_ready + dividend/divisor in;
//        out_valid/out_ready + quotient/remainder/div_by_zero out.
module gf2_poly_div
    import gf2_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-2:0] remainder,
    output logic          div_by_zero
);

    localparam int NW = $clog2(VW);
    localparam int CW = $clog2(DW);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] dvs_q;
    logic [NW-1:0] n_q;
    logic [VW-1:0] r_q;
    logic [DW-1:0] q_q;
    logic          dz_q;

    logic [DW-1:0] quotient_q;
    logic [VW-2:0] remainder_q;
    logic          dbz_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [VW-1:0] r_d;
    logic          q_bit_d;
    logic [DW-1:0] q_d;
    logic [VW-1:0] mask_d;
    logic [VW-2:0] rem_d;

    gf2_div_step #(
        .VW (VW),
        .NW (NW)
    ) u_step (
        .r_i       (r_q),
        .d_i       (dvd_q[cnt_q]),
        .divisor_i (dvs_q),
        .n_i       (n_q),
        .r_next_o  (r_d),
        .q_bit_o   (q_bit_d)
    );

    always_comb begin
        q_d        = q_q;
        q_d[cnt_q] = q_bit_d;
        mask_d     = (VW'(1) << n_q) - VW'(1);
        rem_d      = (VW-1)'(r_d & mask_d);
    end

    // Zero divisors also spend one cycle in DIV (no arithmetic) so that the
    // result registers are only ever loaded on the DIV -> DONE transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            n_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dvd_q      <= dividend;
                        dvs_q      <= divisor;
                        n_q        <= NW'(msb_index(32'(divisor)));
                        r_q        <= '0;
                        q_q        <= '0;
                        cnt_q      <= CW'(DW - 1);
                        dz_q       <= (divisor == '0);
                        in_ready_q <= 1'b0;
                        state_q    <= DIV;
                    end
                end
                DIV: begin
                    if (dz_q) begin
                        quotient_q  <= '0;
                        remainder_q <= '0;
                        dbz_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        r_q <= r_d;
                        q_q <= q_d;
                        if (cnt_q == '0) begin
                            quotient_q  <= q_d;
                            remainder_q <= rem_d;
                            dbz_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf2_poly_div.sv
// Scoreboard bench for gf2_poly_div: directed vectors plus clmul round trips.
// Stimulus pushes expectations; a negedge monitor pops on each handshake.
module tb_gf2_poly_div;

    typedef struct {
        logic [15:0] q;
        logic [6:0]  r;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [6:0]  remainder;
    logic        div_by_zero;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    gf2_poly_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Carry-less product, used to build exact-division test cases.
    function automatic logic [15:0] clmul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got q=0x%0h expected none",
                         quotient);
            end else begin
                mon_e = sbq.pop_front();
                chk("quotient", 32'(quotient), 32'(mon_e.q));
                chk("remainder", 32'(remainder), 32'(mon_e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
            end
        end
    end

    task automatic op(input logic [15:0] a, input logic [7:0] b,
                      input logic [15:0] eq, input logic [6:0] er,
                      input logic ez, input int lat);
        int k;
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = ez;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (lat >= 0) chk("latency", 32'(k), 32'(lat));
        else if (k >= 100) chk("timeout", 32'(k), 32'd0);
        while (out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic saw;
        logic [7:0] a;
        logic [7:0] b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);

        op(16'h0005, 8'h03, 16'h0003, 7'h00, 1'b0, 16);
        op(16'h0007, 8'h03, 16'h0002, 7'h01, 1'b0, 16);
        op(16'h8000, 8'h80, 16'h0100, 7'h00, 1'b0, 16);
        op(16'h1234, 8'h00, 16'h0000, 7'h00, 1'b1, 1);
        op(16'h0005, 8'h13, 16'h0000, 7'h05, 1'b0, 16);
        op(16'h0000, 8'h07, 16'h0000, 7'h00, 1'b0, 16);
        op(16'h00FF, 8'h01, 16'h00FF, 7'h00, 1'b0, 16);

        // Backpressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        sbq.push_back('{16'hBEEF, 7'h00, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = 16'hBEEF;
        divisor  = 8'h01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_latency", 32'(k), 32'd16);
        in_valid = 1'b1;
        dividend = 16'h1111;
        divisor  = 8'h03;
        repeat (5) begin
            @(negedge clk);
            chk("bp_quotient", 32'(quotient), 32'h0000BEEF);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_no_stale_accept", 32'(in_ready), 32'd1);

        // Reset in the middle of a division discards the partial result.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h05;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        saw = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            saw = saw | out_valid;
        end
        chk("midrst_no_result", 32'(saw), 32'd0);

        // Exact division of carry-less products: quotient a, remainder 0.
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            op(clmul(a, b), b, 16'(a), 7'h00, 1'b0, 16);
        end

        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        if (sbq.size() != 0) chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
